// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage between fetch and register-read.
//
// Each accepted instruction is decoded combinationally and the result is
// stored, so every out_* signal comes straight from a flop.
//
// Parameters:
//   XLEN   - datapath width (32 or 64); immediates and PC use this width
//   SKID   - 0: single output register; 1: 2-entry skid FIFO
//   CSR_EN - 1: decode Zicsr ops; 0: system ops with funct3 != 000 are illegal
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   flush                           drop held and incoming instructions
//   in_valid/in_ready               fetch handshake (in_instr, in_pc)
//   out_valid/out_ready             downstream handshake
//   out_pc, out_rd/rs1/rs2,         PC, register indices
//   out_funct3, out_funct7b5        funct fields for the ALU decoder
//   out_imm                         sign-extended immediate
//   out_reg_write .. out_op1_src    control bits
//   out_mem_to_reg, out_alu_op      writeback select, ALU class
//   out_is_ecall, out_is_ebreak,    system/exception flags
//   out_csr_op, out_illegal
module decode_stage #(
    parameter int XLEN   = 32,
    parameter int SKID   = 1,
    parameter int CSR_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_write,
    output logic            out_alu_src,
    output logic            out_mem_write,
    output logic            out_mem_read,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_op1_src,
    output logic [1:0]      out_mem_to_reg,
    output logic [2:0]      out_alu_op,
    output logic            out_is_ecall,
    output logic            out_is_ebreak,
    output logic            out_csr_op,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic            mem_read;
        logic            branch;
        logic            jump;
        logic            op1_src;
        logic [1:0]      mem_to_reg;
        logic [2:0]      alu_op;
        logic            is_ecall;
        logic            is_ebreak;
        logic            csr_op;
        logic            illegal;
    } bundle_t;

    function automatic bundle_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        bundle_t     b;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
        b        = '0;
        imm_i    = {{20{instr[31]}}, instr[31:20]};
        imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u    = {instr[31:12], 12'h000};
        imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        imm32    = '0;
        b.pc       = pc;
        b.rd       = instr[11:7];
        b.rs1      = instr[19:15];
        b.rs2      = instr[24:20];
        b.funct3   = instr[14:12];
        b.funct7b5 = instr[30];
        case (instr[6:2])
            5'b01100: begin b.reg_write = 1'b1; b.alu_op = 3'b010; end
            5'b00100: begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.alu_op = 3'b011; imm32 = imm_i; end
            5'b00000: begin
                b.alu_src = 1'b1; b.reg_write = 1'b1; b.mem_read = 1'b1;
                b.mem_to_reg = 2'b01; imm32 = imm_i;
            end
            5'b01000: begin b.alu_src = 1'b1; b.mem_write = 1'b1; imm32 = imm_s; end
            5'b11000: begin b.branch = 1'b1; b.alu_op = 3'b001; imm32 = imm_b; end
            5'b11011: begin
                b.jump = 1'b1; b.reg_write = 1'b1; b.alu_src = 1'b1; b.op1_src = 1'b1;
                b.mem_to_reg = 2'b10; imm32 = imm_j;
            end
            5'b11001: begin
                b.jump = 1'b1; b.reg_write = 1'b1; b.alu_src = 1'b1;
                b.mem_to_reg = 2'b10; imm32 = imm_i;
            end
            5'b01101: begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.alu_op = 3'b101; imm32 = imm_u; end
            5'b00101: begin b.alu_src = 1'b1; b.reg_write = 1'b1; b.op1_src = 1'b1; imm32 = imm_u; end
            5'b11100: begin
                imm32 = imm_i;
                if (instr[14:12] == 3'b000) begin
                    // Only ECALL and EBREAK are recognised in the funct3=000 space.
                    if (instr[31:20] == 12'h000)      b.is_ecall  = 1'b1;
                    else if (instr[31:20] == 12'h001) b.is_ebreak = 1'b1;
                    else                              b.illegal   = 1'b1;
                end else if (instr[14:12] != 3'b100 && CSR_EN != 0) begin
                    b.csr_op = 1'b1; b.reg_write = 1'b1; b.mem_to_reg = 2'b11;
                end else begin
                    b.illegal = 1'b1;
                end
            end
            5'b00011: ;  // FENCE decodes as a NOP
            default:  b.illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) b.illegal = 1'b1;
        // An illegal instruction must not produce any architectural side effect.
        if (b.illegal) begin
            b.reg_write = 1'b0; b.mem_write = 1'b0; b.mem_read = 1'b0;
            b.branch    = 1'b0; b.jump      = 1'b0;
        end
        b.imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        return b;
    endfunction

    bundle_t    ent0_q, ent0_d, ent1_q, ent1_d, new_ent;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign new_ent   = decode(in_instr, in_pc);
    assign out_valid = (count_q != 2'd0);
    // SKID=1 looks only at stored occupancy, so in_ready never depends on out_ready.
    assign in_ready  = !rst && ((SKID != 0) ? (count_q != 2'd2) : (!out_valid || out_ready));
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready && !flush;

    // Shift-register FIFO: entry 0 is always the head shown on the outputs.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                if (count_q == 2'd2) begin
                    ent0_d = ent1_q;
                    if (push) ent1_d = new_ent;
                end else if (push) begin
                    ent0_d = new_ent;
                end
            end else if (push) begin
                if (count_q == 2'd0) ent0_d = new_ent;
                else                 ent1_d = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign out_pc         = ent0_q.pc;
    assign out_rd         = ent0_q.rd;
    assign out_rs1        = ent0_q.rs1;
    assign out_rs2        = ent0_q.rs2;
    assign out_funct3     = ent0_q.funct3;
    assign out_funct7b5   = ent0_q.funct7b5;
    assign out_imm        = ent0_q.imm;
    assign out_reg_write  = ent0_q.reg_write;
    assign out_alu_src    = ent0_q.alu_src;
    assign out_mem_write  = ent0_q.mem_write;
    assign out_mem_read   = ent0_q.mem_read;
    assign out_branch     = ent0_q.branch;
    assign out_jump       = ent0_q.jump;
    assign out_op1_src    = ent0_q.op1_src;
    assign out_mem_to_reg = ent0_q.mem_to_reg;
    assign out_alu_op     = ent0_q.alu_op;
    assign out_is_ecall   = ent0_q.is_ecall;
    assign out_is_ebreak  = ent0_q.is_ebreak;
    assign out_csr_op     = ent0_q.csr_op;
    assign out_illegal    = ent0_q.illegal;

endmodule
